// File: rtl/acumulador_somador_pkg.sv
// Shared definitions for the acumulador_somador slice: operation encoding,
// FSM state encoding and the saturation limits of the 16-bit accumulator.
// The saturating build is selected with the macro ACUMULADOR_SATURATE_EN.
package acumulador_somador_pkg;

  // Operation encoding shared with somador
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Accumulator width and its two's-complement limits
  localparam int ACC_W = 16;
  localparam logic [ACC_W-1:0] ACC_MAX = 16'h7FFF;
  localparam logic [ACC_W-1:0] ACC_MIN = 16'h8000;

  // Stage sequencing: capture, compute, write back
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  // Saturation value for an overflowing operation; the overflow direction
  // always follows the sign of the accumulator (a) side.
  function automatic logic [ACC_W-1:0] sat_limit(input logic acc_negative);
    logic [ACC_W-1:0] lim;
    if (acc_negative) begin
      lim = ACC_MIN;
    end else begin
      lim = ACC_MAX;
    end
    return lim;
  endfunction

endpackage

// File: rtl/acumulador_somador_somador.sv
// somador: combinational signed adder/subtractor. The operation is evaluated
// one bit wider than the operands so overflow is exact, including the
// subtraction of the most negative value.
module somador
  import acumulador_somador_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             overflow,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH:0] a_ext_s;
  logic [WIDTH:0] b_ext_s;
  logic [WIDTH:0] full_s;

  // Sign-extended add/subtract with overflow from the two top bits
  always_comb begin
    a_ext_s = {a[WIDTH-1], a};
    b_ext_s = {b[WIDTH-1], b};
    if (op == OP_ADD) begin
      full_s = a_ext_s + b_ext_s;
    end else begin
      full_s = a_ext_s - b_ext_s;
    end
    overflow = full_s[WIDTH] ^ full_s[WIDTH-1];
    result   = full_s[WIDTH-1:0];
  end

endmodule

// File: rtl/acumulador_somador.sv
// acumulador_somador: three-cycle accumulator stage around one somador.
// IDLE captures an operand, EXEC registers the somador result, WB commits
// it to acc_out with a one-cycle out_valid pulse. Clear and reset both
// return the stage to IDLE with zeroed state, discarding any operation in
// flight. Define ACUMULADOR_SATURATE_EN to saturate instead of wrapping.
module acumulador_somador
  import acumulador_somador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic             op,
  output logic [WIDTH-1:0] acc_out,
  output logic             out_valid,
  output logic             last_overflow,
  output logic             overflow_flag,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_r;
  logic [WIDTH-1:0] operand_r;
  logic             op_r;
  logic [WIDTH-1:0] res_r;
  logic             res_ovf_r;
  logic [WIDTH-1:0] acc_r;
  logic             out_valid_r;
  logic             last_ovf_r;
  logic             ovf_flag_r;
  logic [CNT_W-1:0] count_r;
  logic             in_ready_r;

  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic [WIDTH-1:0] wb_value_s;

  somador #(
    .WIDTH (WIDTH)
  ) u_somador (
    .a        (acc_r),
    .b        (operand_r),
    .op       (op_r),
    .overflow (ovf_s),
    .result   (sum_s)
  );

  // Value to commit: wrapped sum, or the clamped limit in the saturating build
  always_comb begin
    wb_value_s = sum_s;
`ifdef ACUMULADOR_SATURATE_EN
    if (ovf_s) begin
      wb_value_s = WIDTH'(sat_limit(acc_r[WIDTH-1]));
    end else begin
      wb_value_s = sum_s;
    end
`endif
  end

  // Sequencing FSM with all stage registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      operand_r   <= {WIDTH{1'b0}};
      op_r        <= OP_SUB;
      res_r       <= {WIDTH{1'b0}};
      res_ovf_r   <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      last_ovf_r  <= 1'b0;
      ovf_flag_r  <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
    end else if (clear) begin
      state_r     <= ST_IDLE;
      res_ovf_r   <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      last_ovf_r  <= 1'b0;
      ovf_flag_r  <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            operand_r  <= operand;
            op_r       <= op;
            in_ready_r <= 1'b0;
            state_r    <= ST_EXEC;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          res_r     <= wb_value_s;
          res_ovf_r <= ovf_s;
          state_r   <= ST_WB;
        end
        ST_WB: begin
          acc_r       <= res_r;
          last_ovf_r  <= res_ovf_r;
          ovf_flag_r  <= ovf_flag_r | res_ovf_r;
          count_r     <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          out_valid_r <= 1'b1;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_r;
  assign acc_out       = acc_r;
  assign out_valid     = out_valid_r;
  assign last_overflow = last_ovf_r;
  assign overflow_flag = ovf_flag_r;
  assign op_count      = count_r;

endmodule

// File: tb/tb_acumulador_somador.sv
// Self-checking bench for acumulador_somador: directed scenarios plus random
// operations, checked against an integer-arithmetic reference model.
// Honours ACUMULADOR_SATURATE_EN the same way as the design.
module tb_acumulador_somador;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] operand;
  logic        op;
  logic [15:0] acc_out;
  logic        out_valid;
  logic        last_overflow;
  logic        overflow_flag;
  logic [7:0]  op_count;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_acc  = 0;
  bit m_last = 1'b0;
  bit m_flag = 1'b0;
  int m_cnt  = 0;

  acumulador_somador dut (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .operand       (operand),
    .op            (op),
    .acc_out       (acc_out),
    .out_valid     (out_valid),
    .last_overflow (last_overflow),
    .overflow_flag (overflow_flag),
    .op_count      (op_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_last = 1'b0;
    m_flag = 1'b0;
    m_cnt  = 0;
  endtask

  // Exact integer arithmetic, then wrap or clamp into 16-bit signed range
  task automatic model_apply(input logic o, input logic [15:0] b);
    int bs;
    int exact;
    bit ovf;
    logic [15:0] w;
    bs    = int'($signed(b));
    exact = o ? (m_acc + bs) : (m_acc - bs);
    ovf   = (exact > 32767) || (exact < -32768);
`ifdef ACUMULADOR_SATURATE_EN
    if (exact > 32767) m_acc = 32767;
    else if (exact < -32768) m_acc = -32768;
    else m_acc = exact;
`else
    w     = exact[15:0];
    m_acc = int'($signed(w));
`endif
    m_last = ovf;
    m_flag = m_flag | ovf;
    m_cnt  = (m_cnt + 1) % 256;
  endtask

  task automatic check_state(input string tag);
    check({tag, " acc"},   {16'h0000, acc_out},       {16'h0000, m_acc[15:0]});
    check({tag, " last"},  {31'd0, last_overflow},    {31'd0, m_last});
    check({tag, " flag"},  {31'd0, overflow_flag},    {31'd0, m_flag});
    check({tag, " count"}, {24'd0, op_count},         m_cnt & 32'hFF);
  endtask

  // One full operation starting at a negedge with the stage idle
  task automatic do_op(input logic o, input logic [15:0] b, input string tag);
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op       = o;
    operand  = b;
    @(negedge clock);
    in_valid = 1'b0;
    operand  = 16'($urandom);
    op       = 1'($urandom);
    check({tag, " busy"}, {31'd0, in_ready}, 32'd0);
    check({tag, " early1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check({tag, " early2"}, {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    model_apply(o, b);
    check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    check_state(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] rb;
    logic        ro;
    int          cyc;
    int          last_pulse;
    int          pulses;

    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    operand  = 16'h0000;
    op       = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // reset state
    check("rst ready", {31'd0, in_ready}, 32'd1);
    check("rst valid", {31'd0, out_valid}, 32'd0);
    check_state("rst");

    // basic accumulation
    do_op(1'b1, 16'd35, "add35");
    do_op(1'b1, 16'd72, "add72");
    check("sum107", {16'h0000, acc_out}, 32'd107);

    // positive overflow: wrap to -32768 or saturate to 32767
    do_clear();
    do_op(1'b1, 16'd32512, "pre32512");
    do_op(1'b1, 16'd256, "povf");
`ifdef ACUMULADOR_SATURATE_EN
    check("povf sat", {16'h0000, acc_out}, 32'h7FFF);
`else
    check("povf wrap", {16'h0000, acc_out}, 32'h8000);
`endif
    check("povf last", {31'd0, last_overflow}, 32'd1);

    // negative no-overflow path
    do_clear();
    do_op(1'b0, 16'd256, "to-256");
    do_op(1'b0, 16'd256, "sub256");
    check("m512", {16'h0000, acc_out}, 32'hFE00);
    do_op(1'b1, 16'd512, "add512");

    // negative overflow then sticky flag through a clean op
    do_clear();
    do_op(1'b0, 16'd28576, "to-28576");
    do_op(1'b0, 16'd25604, "novf");
`ifndef ACUMULADOR_SATURATE_EN
    check("novf wrap", {16'h0000, acc_out}, 32'd11356);
`endif
    do_op(1'b1, 16'd1, "sticky");
    check("sticky flag", {31'd0, overflow_flag}, 32'd1);

    // subtracting the most negative value overflows
    do_clear();
    do_op(1'b0, 16'h8000, "sub-min");

    // clear during EXEC with in_valid high discards the operation
    do_op(1'b1, 16'd7, "pre-clr");
    in_valid = 1'b1;
    op       = 1'b1;
    operand  = 16'd5;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check("clrx valid", {31'd0, out_valid}, 32'd0);
    check("clrx ready", {31'd0, in_ready}, 32'd1);
    check_state("clrx");
    @(negedge clock);
    @(negedge clock);
    check("clrx nopulse", {31'd0, out_valid}, 32'd0);

    // clear beats in_valid in IDLE: operand not accepted
    do_op(1'b1, 16'd9, "pre-clri");
    clear    = 1'b1;
    in_valid = 1'b1;
    operand  = 16'd100;
    @(negedge clock);
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check("clri ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("clri nopulse", {31'd0, out_valid}, 32'd0);
    check_state("clri");

    // random operations, biased towards extreme operands
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: rb = 16'h8000;
        1: rb = 16'h7FFF;
        2: rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      ro = 1'($urandom);
      do_op(ro, rb, "rand");
    end

    // in_valid held high: one accept per 3 cycles, 256 ops wrap the counter
    do_clear();
    in_valid   = 1'b1;
    op         = 1'b1;
    operand    = 16'd3;
    cyc        = 0;
    last_pulse = 0;
    pulses     = 0;
    while (pulses < 256 && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      if (out_valid === 1'b1) begin
        check("stream gap", cyc - last_pulse, 32'd3);
        last_pulse = cyc;
        pulses++;
        model_apply(1'b1, 16'd3);
        check("stream acc", {16'h0000, acc_out}, {16'h0000, m_acc[15:0]});
        if (pulses == 256) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stream pulses", pulses, 32'd256);
    check("stream wrap", {24'd0, op_count}, 32'd0);
    check_state("stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
